// File: rtl/phrase_sequencer_if.sv
// phrase_sequencer_if
//   Bundles the phrase-store read port and the four voice-engine trigger
//   channels of the phrase sequencer.
//   master : sequencer side (drives row, triggers, strobes)
//   slave  : store/voice side (drives channel words and ready)
//   Signals:
//     row          row index to the phrase store read port
//     ch_data_0..3 phrase words for the current row {note, vol, inst}
//     note_data_0..3 latched trigger payload per channel
//     note_valid   per-channel trigger valid
//     note_ready   per-channel trigger accept
//     row_strobe   one-cycle pulse when a row is issued
//     overrun      one-cycle pulse: an unaccepted trigger was replaced
interface phrase_sequencer_if;
    logic [3:0]  row;
    logic [15:0] ch_data_0;
    logic [15:0] ch_data_1;
    logic [15:0] ch_data_2;
    logic [15:0] ch_data_3;
    logic [15:0] note_data_0;
    logic [15:0] note_data_1;
    logic [15:0] note_data_2;
    logic [15:0] note_data_3;
    logic [3:0]  note_valid;
    logic [3:0]  note_ready;
    logic        row_strobe;
    logic [3:0]  overrun;

    modport master (
        output row, note_data_0, note_data_1, note_data_2, note_data_3,
               note_valid, row_strobe, overrun,
        input  ch_data_0, ch_data_1, ch_data_2, ch_data_3, note_ready
    );

    modport slave (
        input  row, note_data_0, note_data_1, note_data_2, note_data_3,
               note_valid, row_strobe, overrun,
        output ch_data_0, ch_data_1, ch_data_2, ch_data_3, note_ready
    );
endinterface

// File: rtl/phrase_sequencer.sv
// phrase_sequencer
//   Playback controller for the 4-channel phrase store. Steps the row index
//   at a programmable tempo, samples the four channel words of each row and
//   raises per-channel note triggers towards the voice engines.
//   Ports:
//     clk, rst_active_high  clock and asynchronous active-high reset
//     play_pause            level, 1 = play, 0 = pause
//     stop                  pulse, halt and rewind to row 0 (beats play_pause)
//     row_ms                tempo ticks per row (0 behaves as 1)
//     playing               high while fetching/issuing/waiting; gates edits
//     phrase_done           (SEQ_ONESHOT_EN only) pulse when the phrase ends
//     bus                   phrase store / voice trigger interface (master)
//   Build option: define SEQ_ONESHOT_EN to stop after the last row instead
//   of looping.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   STOPPED  | idle at row 0, waiting for play
//   FETCH    | row stable, store output settling
//   ISSUE    | sample channel words, raise triggers, load row timer
//   WAIT     | prescaler/row timer running until the row expires
//   PAUSED   | everything frozen; resumes into the state that was left
module phrase_sequencer #(
    parameter int CLK_DIV  = 100000,
    parameter int NUM_ROWS = 16
) (
    input  logic               clk,
    input  logic               rst_active_high,
    input  logic               play_pause,
    input  logic               stop,
    input  logic [9:0]         row_ms,
    output logic               playing,
`ifdef SEQ_ONESHOT_EN
    output logic               phrase_done,
`endif
    phrase_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_PAUSED
    } state_t;

    localparam int             PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [3:0]     ROW_MASK  = 4'(NUM_ROWS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    state_t        r_resume;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_timer;
    logic [3:0]    r_row;
    logic [3:0]    r_valid;
    logic [3:0]    r_overrun;
    logic [15:0]   r_note [4];
    logic [15:0]   w_ch   [4];
    logic [9:0]    w_row_len;
    logic          w_issue;
    logic          w_run;
    logic          w_tick;
    logic          w_expire;
    logic          w_phrase_end;

    assign w_ch[0] = bus.ch_data_0;
    assign w_ch[1] = bus.ch_data_1;
    assign w_ch[2] = bus.ch_data_2;
    assign w_ch[3] = bus.ch_data_3;

    assign w_row_len = (row_ms == 10'd0) ? 10'd1 : row_ms;
    assign w_tick    = (r_presc == PRESC_MAX);
    // The row ends on the tick that takes the timer from 1 to 0.
    assign w_expire  = w_tick && (r_timer == 10'd1);

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_state  <= ST_STOPPED;
            r_resume <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
            // Tracks the last active state so PAUSED knows where to return.
            if (r_state != ST_PAUSED) begin
                r_resume <= r_state;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_run        = 1'b0;
        w_phrase_end = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                if (play_pause) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_nxt = play_pause ? ST_ISSUE : ST_PAUSED;
            end
            ST_ISSUE: begin
                // A pause seen in ISSUE defers the trigger to the resume,
                // so each row is issued exactly once.
                if (play_pause) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_WAIT: begin
                if (!play_pause) begin
                    w_state_nxt = ST_PAUSED;
                end else begin
                    w_run = 1'b1;
                    if (w_expire) begin
`ifdef SEQ_ONESHOT_EN
                        if (r_row == ROW_MASK) begin
                            w_state_nxt  = ST_STOPPED;
                            w_phrase_end = 1'b1;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
`else
                        w_state_nxt = ST_FETCH;
`endif
                    end
                end
            end
            ST_PAUSED: begin
                if (play_pause) w_state_nxt = r_resume;
            end
            default: w_state_nxt = ST_STOPPED;
        endcase
        if (stop) begin
            w_state_nxt  = ST_STOPPED;
            w_issue      = 1'b0;
            w_run        = 1'b0;
            w_phrase_end = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_row     <= '0;
            r_presc   <= '0;
            r_timer   <= '0;
            r_valid   <= '0;
            r_overrun <= '0;
            for (int c = 0; c < 4; c++) r_note[c] <= '0;
        end else if (stop) begin
            r_row     <= '0;
            r_presc   <= '0;
            r_timer   <= '0;
            r_valid   <= '0;
            r_overrun <= '0;
        end else begin
            r_overrun <= '0;
            for (int c = 0; c < 4; c++) begin
                r_valid[c] <= r_valid[c] & ~bus.note_ready[c];
                // New data always wins; flag it if the old trigger was
                // still pending and not being accepted this cycle.
                if (w_issue && (w_ch[c] != 16'hFFFF)) begin
                    r_note[c]    <= w_ch[c];
                    r_valid[c]   <= 1'b1;
                    r_overrun[c] <= r_valid[c] & ~bus.note_ready[c];
                end
            end
            if (w_issue) begin
                r_timer <= w_row_len;
                r_presc <= '0;
            end else if (w_run) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) r_timer <= r_timer - 10'd1;
                if (w_expire) r_row <= w_phrase_end ? 4'd0 : ((r_row + 4'd1) & ROW_MASK);
            end
        end
    end

`ifdef SEQ_ONESHOT_EN
    logic r_phrase_done;

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_phrase_done <= 1'b0;
        end else begin
            r_phrase_done <= w_phrase_end;
        end
    end

    assign phrase_done = r_phrase_done;
`endif

    assign playing         = (r_state == ST_FETCH) || (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.row         = r_row;
    assign bus.row_strobe  = w_issue;
    assign bus.note_valid  = r_valid;
    assign bus.overrun     = r_overrun;
    assign bus.note_data_0 = r_note[0];
    assign bus.note_data_1 = r_note[1];
    assign bus.note_data_2 = r_note[2];
    assign bus.note_data_3 = r_note[3];

endmodule
